// File: rtl/divider_pkg.sv
// Shared types and defaults for the multi-cycle restoring divider.
package divider_pkg;

  localparam int unsigned DIV_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring shift-subtract iteration: shift in a dividend bit, subtract the divisor if it fits.
module divider_step
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] diff;

  // Compare at WIDTH+1 bits so divisors with the MSB set still divide correctly;
  // when the divisor fits, the true difference is below 2^WIDTH, so the low bits suffice.
  always_comb begin
    rem_shift = {rem_in, dvd_msb};
    diff      = rem_shift[WIDTH-1:0] - dvs;
    q_bit     = (rem_shift >= {1'b0, dvs});
    rem_out   = q_bit ? diff : rem_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_module.sv
// Multi-cycle unsigned divider, one quotient bit per clock with start/Ready handshake.
// Optional divide-by-zero flag output enabled by defining DIV_ZERO_FLAG_EN.
module divider_module
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Dividendo,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Ready,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Reminder
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic             Div_zero
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] reminder_q, reminder_d;
  logic             ready_q, ready_d;
  logic             start_q, start_d;
`ifdef DIV_ZERO_FLAG_EN
  logic             div_zero_q, div_zero_d;
`endif

  logic             launch_c;
  logic [WIDTH-1:0] step_rem_c;
  logic             step_qbit_c;

  divider_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (rem_q),
    .dvd_msb(dvd_q[WIDTH-1]),
    .dvs    (dvs_q),
    .rem_out(step_rem_c),
    .q_bit  (step_qbit_c)
  );

  assign launch_c = start & ~start_q;

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    result_d   = result_q;
    reminder_d = reminder_q;
    ready_d    = ready_q;
    start_d    = start;
`ifdef DIV_ZERO_FLAG_EN
    div_zero_d = div_zero_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (launch_c) begin
          dvd_d   = Dividendo;
          dvs_d   = Divisor;
          rem_d   = '0;
          quo_d   = '0;
          count_d = '0;
          ready_d = 1'b0;
          state_d = BUSY;
`ifdef DIV_ZERO_FLAG_EN
          div_zero_d = 1'b0;
`endif
        end
      end
      BUSY: begin
        rem_d   = step_rem_c;
        dvd_d   = {dvd_q[WIDTH-2:0], 1'b0};
        quo_d   = {quo_q[WIDTH-2:0], step_qbit_c};
        count_d = count_q + CNT_W'(1);
        // Final iteration publishes the results in the same edge.
        if (count_q == CNT_W'(WIDTH - 1)) begin
          result_d   = {quo_q[WIDTH-2:0], step_qbit_c};
          reminder_d = step_rem_c;
          ready_d    = 1'b1;
          state_d    = DONE;
`ifdef DIV_ZERO_FLAG_EN
          div_zero_d = (dvs_q == '0);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      result_q   <= '0;
      reminder_q <= '0;
      ready_q    <= 1'b0;
      start_q    <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      result_q   <= result_d;
      reminder_q <= reminder_d;
      ready_q    <= ready_d;
      start_q    <= start_d;
`ifdef DIV_ZERO_FLAG_EN
      div_zero_q <= div_zero_d;
`endif
    end
  end

  assign Ready    = ready_q;
  assign Result   = result_q;
  assign Reminder = reminder_q;
`ifdef DIV_ZERO_FLAG_EN
  assign Div_zero = div_zero_q;
`endif

endmodule

// File: tb/tb_divider_module.sv
// Self-checking bench for divider_module: directed cases plus random operands vs. arithmetic model.
module tb_divider_module;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] Dividendo;
  logic [W-1:0] Divisor;
  logic         Ready;
  logic [W-1:0] Result;
  logic [W-1:0] Reminder;
`ifdef DIV_ZERO_FLAG_EN
  logic         Div_zero;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_res_last;

  divider_module #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .Dividendo(Dividendo),
    .Divisor  (Divisor),
    .Ready    (Ready),
    .Result   (Result),
    .Reminder (Reminder)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .Div_zero (Div_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division; a zero divisor gives all ones and the dividend back.
  function automatic logic [W-1:0] ref_quo(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) ? '1 : W'(a / b);
  endfunction

  function automatic logic [W-1:0] ref_rem(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) ? a : W'(a % b);
  endfunction

  // Launch one divide, hold start for 'hold' edges, optionally scramble operands while busy.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit scramble);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    @(negedge clk);
    Dividendo = a;
    Divisor   = b;
    start     = 1'b1;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == hold) start = 1'b0;
      if (scramble) begin
        Dividendo = W'($urandom);
        Divisor   = W'($urandom);
      end
      if (n == 1) check("ready_drop", 32'(Ready), 32'd0);
      if (n == 8) check("result_hold", 32'(Result), 32'(exp_res_last));
      if (Ready) done = 1'b1;
    end
    start = 1'b0;
    check("latency", 32'(n), 32'd17);
    check("quotient", 32'(Result), 32'(ref_quo(a, b)));
    check("remainder", 32'(Reminder), 32'(ref_rem(a, b)));
`ifdef DIV_ZERO_FLAG_EN
    check("div_zero", 32'(Div_zero), 32'(b == '0));
`endif
    exp_res_last = ref_quo(a, b);
  endtask

  initial begin
    logic [W-1:0] a, b;
    rst          = 1'b1;
    start        = 1'b0;
    Dividendo    = '0;
    Divisor      = '0;
    exp_res_last = '0;

    #1;
    check("rst_ready", 32'(Ready), 32'd0);
    check("rst_result", 32'(Result), 32'd0);
    check("rst_rem", 32'(Reminder), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_div(16'd59, 16'd6, 1, 1'b0);
    do_div(16'hFFFF, 16'd1, 1, 1'b0);
    do_div(16'd3, 16'd7, 1, 1'b0);
    do_div(16'd100, 16'd0, 1, 1'b0);

    // Long start with operand churn: exactly one operation, then Ready stays up.
    do_div(16'd40000, 16'd123, 5, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("ready_stays", 32'(Ready), 32'd1);
      check("result_stays", 32'(Result), 32'(ref_quo(16'd40000, 16'd123)));
    end

    // Abort mid-operation with reset.
    @(negedge clk);
    Dividendo = 16'd59;
    Divisor   = 16'd6;
    start     = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b1;
    #1;
    check("abort_ready", 32'(Ready), 32'd0);
    check("abort_result", 32'(Result), 32'd0);
    check("abort_rem", 32'(Reminder), 32'd0);
    @(negedge clk);
    rst          = 1'b0;
    exp_res_last = '0;
    do_div(16'd1000, 16'd10, 1, 1'b0);

    // Back-to-back launch from DONE.
    do_div(16'd50, 16'd7, 1, 1'b0);

    // Random operands, mixing small, large and zero divisors.
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom);
      case (i % 4)
        0:       b = W'($urandom);
        1:       b = W'($urandom_range(1, 15));
        2:       b = 16'h8000 | W'($urandom);
        default: b = (i % 8 == 3) ? '0 : W'($urandom_range(1, 300));
      endcase
      do_div(a, b, 1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
